miriscv_rvfi_serializer: RTL and testbench

- Collects up to NRET RVFI retirements per cycle from a multi-issue core and buffers them in a DEPTH-entry FIFO.
- Replays them one per cycle on a single valid/ready RVFI channel, for existing single-retire monitors and trace writers.
- Checks that rvfi_order is contiguous, and freezes the output stream on the first retired halt.
- Sits between the core's RVFI port and the testbench monitor/scoreboard.

---
 rtl/miriscv_rvfi_serializer.sv | 146 ++++++++++++++
 tb/tb_miriscv_rvfi_serializer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_rvfi_serializer.sv
// Serializes up to NRET RVFI retirements per cycle into a single valid/ready stream.
// Optional retirement statistics outputs: define MIRISCV_RVFI_SER_STATS_EN.
module miriscv_rvfi_serializer #(
  parameter int NRET    = 2,
  parameter int XLEN    = 32,
  parameter int DEPTH   = 8,
  parameter int ORDER_W = 64,
  localparam int PKT_W  = 43 + 5*XLEN,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic [NRET-1:0]           in_valid,
  input  logic [NRET*ORDER_W-1:0]   in_order,
  input  logic [NRET*PKT_W-1:0]     in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ORDER_W-1:0]        out_order,
  output logic [PKT_W-1:0]          out_data,
  output logic                      order_err,
  output logic                      overflow,
  output logic                      halted
`ifdef MIRISCV_RVFI_SER_STATS_EN
  ,
  output logic [31:0]               ret_cnt,
  output logic [31:0]               trap_cnt,
  output logic [CW-1:0]             max_fill
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {RUN, HALTED} state_e;

  typedef struct packed {
    logic [ORDER_W-1:0] order;
    logic [PKT_W-1:0]   data;
  } ent_t;

  state_e             state_q, state_d;
  ent_t               mem_q [DEPTH];
  ent_t               mem_d [DEPTH];
  logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d, widx;
  logic [CW-1:0]      count_q, count_d, npush;
  logic [ORDER_W-1:0] exp_order_q, exp_order_d;
  logic               order_err_q, order_err_d;
  logic               overflow_q, overflow_d;
  logic               pop;
  ent_t               head;

  assign head      = mem_q[rptr_q];
  assign in_ready  = (state_q == RUN) && (count_q <= CW'(DEPTH - NRET));
  assign out_valid = (count_q != '0) && (state_q == RUN);
  // Head is gated so idle/reset outputs read as zero rather than stale storage.
  assign out_order = out_valid ? head.order : '0;
  assign out_data  = out_valid ? head.data  : '0;
  assign pop       = out_valid && out_ready;
  assign order_err = order_err_q;
  assign overflow  = overflow_q;
  assign halted    = (state_q == HALTED);

  always_comb begin
    mem_d       = mem_q;
    widx        = wptr_q;
    npush       = '0;
    state_d     = state_q;
    exp_order_d = exp_order_q;
    order_err_d = order_err_q;
    overflow_d  = overflow_q | (|in_valid && !in_ready);
    // Compact valid lanes into consecutive slots so sparse valids leave no holes.
    if (in_ready) begin
      for (int i = 0; i < NRET; i++) begin
        if (in_valid[i]) begin
          mem_d[widx] = '{order: in_order[i*ORDER_W +: ORDER_W],
                          data:  in_data[i*PKT_W +: PKT_W]};
          widx  = widx + AW'(1);
          npush = npush + CW'(1);
        end
      end
    end
    wptr_d  = widx;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + npush - CW'(pop);
    if (pop) begin
      if (head.order != exp_order_q) order_err_d = 1'b1;
      exp_order_d = head.order + ORDER_W'(1);
      if (head.data[PKT_W-1]) state_d = HALTED;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= RUN;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      exp_order_q <= '0;
      order_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      exp_order_q <= exp_order_d;
      order_err_q <= order_err_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef MIRISCV_RVFI_SER_STATS_EN
  logic [31:0]   ret_cnt_q, ret_cnt_d, trap_cnt_q, trap_cnt_d;
  logic [CW-1:0] max_fill_q, max_fill_d;

  always_comb begin
    ret_cnt_d  = ret_cnt_q;
    trap_cnt_d = trap_cnt_q;
    max_fill_d = (count_d > max_fill_q) ? count_d : max_fill_q;
    if (pop && (ret_cnt_q != '1)) ret_cnt_d = ret_cnt_q + 32'd1;
    if (pop && head.data[PKT_W-2] && (trap_cnt_q != '1)) trap_cnt_d = trap_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ret_cnt_q  <= '0;
      trap_cnt_q <= '0;
      max_fill_q <= '0;
    end else begin
      ret_cnt_q  <= ret_cnt_d;
      trap_cnt_q <= trap_cnt_d;
      max_fill_q <= max_fill_d;
    end
  end

  assign ret_cnt  = ret_cnt_q;
  assign trap_cnt = trap_cnt_q;
  assign max_fill = max_fill_q;
`endif

endmodule

// File: tb/tb_miriscv_rvfi_serializer.sv
// Bench for miriscv_rvfi_serializer: vector table, directed corner sequences, random vs queue model.
module tb_miriscv_rvfi_serializer;
  localparam int NRET = 2, XLEN = 32, DEPTH = 8, ORDER_W = 64;
  localparam int PKT_W = 43 + 5*XLEN;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0, arst = 1'b1;
  logic [NRET-1:0] in_valid;
  logic [NRET*ORDER_W-1:0] in_order;
  logic [NRET*PKT_W-1:0] in_data;
  logic in_ready, out_valid, out_ready, order_err, overflow, halted;
  logic [ORDER_W-1:0] out_order;
  logic [PKT_W-1:0] out_data;
`ifdef MIRISCV_RVFI_SER_STATS_EN
  logic [31:0] ret_cnt, trap_cnt;
  logic [CW-1:0] max_fill;
`endif

  miriscv_rvfi_serializer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH), .ORDER_W(ORDER_W)) dut (
    .clk(clk), .arst(arst), .in_valid(in_valid), .in_order(in_order), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_order(out_order),
    .out_data(out_data), .order_err(order_err), .overflow(overflow), .halted(halted)
`ifdef MIRISCV_RVFI_SER_STATS_EN
    , .ret_cnt(ret_cnt), .trap_cnt(trap_cnt), .max_fill(max_fill)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Reference model: a plain queue of retired entries plus sticky flags.
  typedef struct { logic [63:0] ord; logic [PKT_W-1:0] d; } ment_t;
  ment_t mq[$];
  logic [63:0] m_exp;
  logic m_err, m_ovf, m_hlt;
  logic [1:0] c_vld;
  logic c_ordy;
  logic [63:0] c_o0, c_o1;
  logic [PKT_W-1:0] c_d0, c_d1;

  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [PKT_W-1:0] mk(input logic [63:0] o, input logic h, input logic t);
    logic [PKT_W-1:0] d;
    d = '0;
    d[63:0] = o ^ 64'hA5C3_0F1E_5A3C_F0E1;
    d[127:64] = ~o;
    d[PKT_W-1] = h;
    d[PKT_W-2] = t;
    return d;
  endfunction

  task automatic apply(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                       input logic h0, input logic h1, input logic t0, input logic t1,
                       input logic ordy);
    c_vld = v; c_o0 = o0; c_o1 = o1; c_ordy = ordy;
    c_d0 = mk(o0, h0, t0); c_d1 = mk(o1, h1, t1);
    in_valid = v; in_order = {o1, o0}; in_data = {c_d1, c_d0}; out_ready = ordy;
  endtask

  // Compare against the model before the edge, then advance the model by one cycle.
  task automatic tick();
    logic m_ov, m_ir;
    ment_t e;
    #1;
    m_ov = (mq.size() != 0) && !m_hlt;
    m_ir = !m_hlt && ((DEPTH - mq.size()) >= NRET);
    chk("out_valid", out_valid, m_ov);
    chk("in_ready", in_ready, m_ir);
    chk("order_err", order_err, m_err);
    chk("overflow", overflow, m_ovf);
    chk("halted", halted, m_hlt);
    if (m_ov) begin
      chk("out_order", out_order, mq[0].ord);
      chk("out_data", out_data, mq[0].d);
    end
    @(posedge clk);
    if (m_ov && c_ordy) begin
      e = mq.pop_front();
      if (e.ord != m_exp) m_err = 1'b1;
      m_exp = e.ord + 64'd1;
      if (e.d[PKT_W-1]) m_hlt = 1'b1;
    end
    if (m_ir) begin
      if (c_vld[0]) mq.push_back('{c_o0, c_d0});
      if (c_vld[1]) mq.push_back('{c_o1, c_d1});
    end else if (|c_vld) m_ovf = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    apply(2'b00, 0, 0, 0, 0, 0, 0, 1'b0);
    arst = 1'b1;
    mq.delete(); m_exp = 0; m_err = 0; m_ovf = 0; m_hlt = 0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_order_err", order_err, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_out_order", out_order, 0);
    chk("rst_out_data", out_data, 0);
    @(negedge clk);
    arst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] vld; logic [63:0] o0, o1; logic ordy;
    logic e_ov; logic [63:0] e_oo; logic e_ir, e_err, e_ovf;
  } vec_t;
  vec_t tbl[12];

  initial begin
    logic [63:0] nord;
    logic [1:0] rv;
    logic rh0, rh1;
    // vld, o0, o1, ordy | out_valid, out_order, in_ready, order_err, overflow (pre-edge)
    tbl[0]  = '{2'b11, 0, 1, 1, 0, 0, 1, 0, 0};
    tbl[1]  = '{2'b00, 0, 0, 1, 1, 0, 1, 0, 0};
    tbl[2]  = '{2'b00, 0, 0, 1, 1, 1, 1, 0, 0};
    tbl[3]  = '{2'b10, 0, 2, 1, 0, 0, 1, 0, 0};
    tbl[4]  = '{2'b01, 3, 0, 1, 1, 2, 1, 0, 0};
    tbl[5]  = '{2'b11, 4, 5, 0, 1, 3, 1, 0, 0};
    tbl[6]  = '{2'b11, 6, 7, 0, 1, 3, 1, 0, 0};
    tbl[7]  = '{2'b11, 8, 9, 0, 1, 3, 1, 0, 0};
    tbl[8]  = '{2'b01, 10, 0, 0, 1, 3, 0, 0, 0};
    tbl[9]  = '{2'b00, 0, 0, 1, 1, 3, 0, 0, 1};
    tbl[10] = '{2'b00, 0, 0, 1, 1, 4, 1, 0, 1};
    tbl[11] = '{2'b00, 0, 0, 1, 1, 5, 1, 0, 1};

    do_reset();
    foreach (tbl[i]) begin
      apply(tbl[i].vld, tbl[i].o0, tbl[i].o1, 0, 0, 0, 0, tbl[i].ordy);
      #1;
      chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_order", i), out_order, tbl[i].e_oo);
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_ir);
      chk($sformatf("tbl%0d_order_err", i), order_err, tbl[i].e_err);
      chk($sformatf("tbl%0d_overflow", i), overflow, tbl[i].e_ovf);
      tick();
    end
    for (int k = 0; k < 6; k++) begin apply(0, 0, 0, 0, 0, 0, 0, 1); tick(); end

    // Fill to DEPTH, overflow once, then drain exactly 0..7.
    do_reset();
    for (int k = 0; k < 4; k++) begin apply(2'b11, 2*k, 2*k+1, 0, 0, 0, 0, 0); tick(); end
    apply(2'b01, 8, 0, 0, 0, 0, 0, 0);
    #1 chk("full_in_ready", in_ready, 1'b0);
    tick();
    for (int k = 0; k < 8; k++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 1);
      #1;
      chk("drain_order", out_order, k);
      chk("drain_overflow", overflow, 1'b1);
      tick();
    end
    #1 chk("drain_empty", out_valid, 1'b0);
    @(negedge clk);

    // Order gap 0,1,3,4: sticky error raised once.
    do_reset();
    apply(2'b11, 0, 1, 0, 0, 0, 0, 1); tick();
    apply(2'b01, 3, 0, 0, 0, 0, 0, 1); tick();
    apply(2'b01, 4, 0, 0, 0, 0, 0, 1); tick();
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk("gap_before", order_err, 1'b0);
    tick();
    #1 chk("gap_rise", order_err, 1'b1);
    tick();
    #1 chk("gap_sticky", order_err, 1'b1);
    tick();

    // Halt on order 1: order 2 retained, never emitted; reset recovers.
    do_reset();
    apply(2'b11, 0, 1, 0, 1, 0, 0, 1); tick();
    apply(2'b01, 2, 0, 0, 0, 0, 0, 1); tick();
    apply(0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk("halt_pop_order", out_order, 1);
    tick();
    #1;
    chk("halt_halted", halted, 1'b1);
    chk("halt_out_valid", out_valid, 1'b0);
    chk("halt_in_ready", in_ready, 1'b0);
    for (int k = 0; k < 3; k++) tick();
    do_reset();

`ifdef MIRISCV_RVFI_SER_STATS_EN
    do_reset();
    apply(2'b11, 0, 1, 0, 0, 1, 0, 0); tick();
    apply(2'b01, 2, 0, 0, 0, 0, 0, 0); tick();
    apply(2'b00, 0, 0, 0, 0, 0, 0, 1); tick();
    apply(2'b11, 3, 4, 0, 0, 0, 1, 1); tick();
    for (int k = 0; k < 4; k++) begin apply(0, 0, 0, 0, 0, 0, 0, 1); tick(); end
    chk("stat_ret_cnt", ret_cnt, 5);
    chk("stat_trap_cnt", trap_cnt, 2);
    chk("stat_max_fill", max_fill, 3);
`endif

    // Random traffic with occasional gaps, halts and mid-stream resets.
    nord = 0;
    for (int n = 0; n < 600; n++) begin
      if (n % 80 == 0) begin do_reset(); nord = 0; end
      rv = 2'($urandom_range(0, 3));
      rh0 = ($urandom_range(0, 150) == 0);
      rh1 = ($urandom_range(0, 150) == 0);
      if ($urandom_range(0, 15) == 0) nord = nord + 64'd1;
      apply(rv, nord, rv[0] ? nord + 64'd1 : nord, rh0, rh1,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      nord = nord + 64'(rv[0]) + 64'(rv[1]);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
